// File: rtl/fc_sched.sv
// Fully-connected classifier sequencer: walks every class, streams fm/weight
// read beats to the MAC front-end and keeps a signed running argmax.
// Optional FC_SCHED_SCORE_OUT_EN adds the o_score output (winning score).
module fc_sched #(
  parameter int unsigned N_CLASS = 27,
  parameter int unsigned N_TILE  = 48,
  parameter int unsigned ACC_W   = 21,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [8:0]              i_fm_base_addr,
  input  logic [12:0]             i_wt_base_addr,
  output logic [15:0]             o_fm_addr,
  output logic [15:0]             o_wt_addr,
  output logic                    o_rd_en,
  output logic                    o_mac_clr,
  output logic                    o_mac_en,
  output logic                    o_mac_last,
  input  logic                    i_mac_done,
  input  logic signed [ACC_W-1:0] i_mac_sum,
  output logic                    o_busy,
  output logic                    o_result_valid,
`ifdef FC_SCHED_SCORE_OUT_EN
  output logic signed [ACC_W-1:0] o_score,
`endif
  output logic [4:0]              o_result
);

  localparam int unsigned TILE_W = (N_TILE > 1) ? $clog2(N_TILE) : 1;

  typedef enum logic [2:0] {IDLE, CLR, ISSUE, WAIT, CMP, DONE} state_t;

  state_t                  state, state_nxt;
  logic [8:0]              fm_base;
  logic [12:0]             wt_base;
  logic [4:0]              cls, best_idx;
  logic [TILE_W-1:0]       tile;
  logic signed [ACC_W-1:0] sum, best;
  logic [RD_LAT-1:0]       en_pipe, last_pipe;
  logic                    last_tile, last_cls, take;

  assign last_tile = (tile == TILE_W'(N_TILE - 1));
  assign last_cls  = (cls == 5'(N_CLASS - 1));
  // class 0 always seeds the argmax; strict compare keeps the lower index on ties
  assign take      = (cls == '0) || (sum > best);

  assign o_fm_addr  = 16'(fm_base) + 16'(tile);
  assign o_wt_addr  = 16'(wt_base) + 16'(cls) * 16'(N_TILE) + 16'(tile);
  assign o_mac_en   = en_pipe[RD_LAT-1];
  assign o_mac_last = last_pipe[RD_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    o_rd_en        = 1'b0;
    o_mac_clr      = 1'b0;
    o_busy         = 1'b1;
    o_result_valid = 1'b0;
    unique case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nxt = CLR;
      end
      CLR: begin
        o_mac_clr = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        o_rd_en = 1'b1;
        if (last_tile) state_nxt = WAIT;
      end
      WAIT: if (i_mac_done) state_nxt = CMP;
      CMP:  state_nxt = last_cls ? DONE : CLR;
      DONE: begin
        o_result_valid = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fm_base   <= '0;
      wt_base   <= '0;
      cls       <= '0;
      tile      <= '0;
      sum       <= '0;
      best      <= '0;
      best_idx  <= '0;
      o_result  <= '0;
`ifdef FC_SCHED_SCORE_OUT_EN
      o_score   <= '0;
`endif
      en_pipe   <= '0;
      last_pipe <= '0;
    end else begin
      unique case (state)
        IDLE: if (i_start) begin
          fm_base <= i_fm_base_addr;
          wt_base <= i_wt_base_addr;
          cls     <= '0;
        end
        CLR:   tile <= '0;
        ISSUE: if (!last_tile) tile <= tile + TILE_W'(1);
        WAIT:  if (i_mac_done) sum <= i_mac_sum;
        CMP: begin
          if (take) begin
            best     <= sum;
            best_idx <= cls;
          end
          // final class: publish the post-compare winner directly so it lines up with DONE
          if (last_cls) begin
            o_result <= take ? cls : best_idx;
`ifdef FC_SCHED_SCORE_OUT_EN
            o_score  <= take ? sum : best;
`endif
          end else begin
            cls <= cls + 5'd1;
          end
        end
        default: ;
      endcase
      en_pipe[0]   <= (state == ISSUE);
      last_pipe[0] <= (state == ISSUE) && last_tile;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        en_pipe[i]   <= en_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fc_sched.sv
// Directed bench for fc_sched: reset abort, address sweep, signed argmax,
// ties, ignored handshakes, and a RD_LAT=3 instance for pipeline alignment.
module tb_fc_sched;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_start = 1'b0;
  logic [8:0]         i_fm_base_addr = '0;
  logic [12:0]        i_wt_base_addr = '0;
  logic               i_mac_done = 1'b0;
  logic signed [20:0] i_mac_sum = '0;

  logic [15:0] fm_addr, wt_addr, l3_fm_addr, l3_wt_addr;
  logic        rd_en, mac_clr, mac_en, mac_last, busy, result_valid;
  logic        l3_rd_en, l3_mac_clr, l3_mac_en, l3_mac_last, l3_busy, l3_result_valid;
  logic [4:0]  result, l3_result;
`ifdef FC_SCHED_SCORE_OUT_EN
  logic signed [20:0] score, l3_score;
`endif

  logic signed [20:0] scores [27];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fc_sched #(.N_CLASS(27), .N_TILE(48), .ACC_W(21), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_fm_base_addr(i_fm_base_addr), .i_wt_base_addr(i_wt_base_addr),
    .o_fm_addr(fm_addr), .o_wt_addr(wt_addr), .o_rd_en(rd_en),
    .o_mac_clr(mac_clr), .o_mac_en(mac_en), .o_mac_last(mac_last),
    .i_mac_done(i_mac_done), .i_mac_sum(i_mac_sum),
    .o_busy(busy), .o_result_valid(result_valid),
`ifdef FC_SCHED_SCORE_OUT_EN
    .o_score(score),
`endif
    .o_result(result)
  );

  fc_sched #(.N_CLASS(27), .N_TILE(48), .ACC_W(21), .RD_LAT(3)) dut_lat3 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_fm_base_addr(i_fm_base_addr), .i_wt_base_addr(i_wt_base_addr),
    .o_fm_addr(l3_fm_addr), .o_wt_addr(l3_wt_addr), .o_rd_en(l3_rd_en),
    .o_mac_clr(l3_mac_clr), .o_mac_en(l3_mac_en), .o_mac_last(l3_mac_last),
    .i_mac_done(i_mac_done), .i_mac_sum(i_mac_sum),
    .o_busy(l3_busy), .o_result_valid(l3_result_valid),
`ifdef FC_SCHED_SCORE_OUT_EN
    .o_score(l3_score),
`endif
    .o_result(l3_result)
  );

  // Full run: the MAC responder answers on the cycle o_mac_last is seen (W=1),
  // so every class takes 51 cycles and DONE lands 27*51+1 cycles after start.
  task automatic run_scores(input logic [8:0] fb, input logic [12:0] wb,
                            input bit noise, input logic [4:0] exp_idx, input string tag);
    int cyc = 0, clr_n = 0, en_n = 0, last_n = 0, rv_n = 0, beat = 0;
    int en3_n = 0, last3_n = 0, bad3 = 0;
    logic [2:0]  rd_hist = '0;
    logic [15:0] fa = '1, wa = '1;
    logic [15:0] fa_exp, wa_exp;
    fa_exp = 16'(fb) + 16'd5;
    wa_exp = 16'(wb) + 16'd101;
    @(negedge clk);
    i_fm_base_addr = fb;
    i_wt_base_addr = wb;
    i_start = 1'b1;
    while (rv_n == 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      i_start = 1'b0;
      i_mac_done = 1'b0;
      i_mac_sum = '0;
      if (mac_clr) begin clr_n++; beat = 0; end
      if (rd_en) begin
        if (clr_n == 3 && beat == 5) begin fa = fm_addr; wa = wt_addr; end
        beat++;
        if (noise) begin i_mac_done = 1'b1; i_mac_sum = 21'sh0FFFFF; end
      end
      if (mac_en) en_n++;
      if (mac_last) begin
        last_n++;
        if (clr_n >= 1 && clr_n <= 27) begin i_mac_done = 1'b1; i_mac_sum = scores[clr_n-1]; end
      end
      if (l3_mac_en !== rd_hist[2]) bad3++;
      if (l3_mac_last) begin
        last3_n++;
        if (!l3_mac_en || (en3_n % 48) != 47) bad3++;
      end
      if (l3_mac_en) en3_n++;
      rd_hist = {rd_hist[1:0], rd_en};
      if (noise && busy && (cyc % 7) == 0) i_start = 1'b1;
      if (result_valid) rv_n++;
    end
    i_start = 1'b0;
    n_checks++; if (rv_n !== 1) begin n_fail++; $display("FAIL %s result_valid timeout: got %0d pulses want 1", tag, rv_n); end
    n_checks++; if (cyc !== 27*51+1) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", tag, cyc, 27*51+1); end
    n_checks++; if (result !== exp_idx) begin n_fail++; $display("FAIL %s result: got %0d want %0d", tag, result, exp_idx); end
    n_checks++; if (clr_n !== 27) begin n_fail++; $display("FAIL %s mac_clr count: got %0d want 27", tag, clr_n); end
    n_checks++; if (en_n !== 27*48) begin n_fail++; $display("FAIL %s mac_en count: got %0d want %0d", tag, en_n, 27*48); end
    n_checks++; if (last_n !== 27) begin n_fail++; $display("FAIL %s mac_last count: got %0d want 27", tag, last_n); end
    n_checks++; if (fa !== fa_exp) begin n_fail++; $display("FAIL %s fm_addr c2b5: got %h want %h", tag, fa, fa_exp); end
    n_checks++; if (wa !== wa_exp) begin n_fail++; $display("FAIL %s wt_addr c2b5: got %h want %h", tag, wa, wa_exp); end
    n_checks++; if (bad3 !== 0) begin n_fail++; $display("FAIL %s lat3 alignment: got %0d bad cycles want 0", tag, bad3); end
    n_checks++; if (en3_n !== 27*48 || last3_n !== 27) begin n_fail++; $display("FAIL %s lat3 counts: got en %0d last %0d want 1296 27", tag, en3_n, last3_n); end
    n_checks++; if (l3_result !== exp_idx) begin n_fail++; $display("FAIL %s lat3 result: got %0d want %0d", tag, l3_result, exp_idx); end
`ifdef FC_SCHED_SCORE_OUT_EN
    n_checks++; if (score !== scores[exp_idx]) begin n_fail++; $display("FAIL %s score: got %0d want %0d", tag, score, scores[exp_idx]); end
`endif
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy after done: got %b want 0", tag, busy); end
    rv_n = 0;
    repeat (5) begin
      if (result_valid) rv_n++;
      @(negedge clk);
    end
    n_checks++; if (rv_n !== 0 || result !== exp_idx) begin n_fail++; $display("FAIL %s post-run: got %0d pulses result %0d want 0 %0d", tag, rv_n, result, exp_idx); end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({fm_addr, wt_addr, rd_en, mac_clr, mac_en, mac_last, busy, result_valid, result} !== '0) begin
      n_fail++; $display("FAIL reset outputs: got %h %h %b%b%b%b%b%b %0d want all 0",
                         fm_addr, wt_addr, rd_en, mac_clr, mac_en, mac_last, busy, result_valid, result);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    i_fm_base_addr = 9'h033; i_wt_base_addr = 13'h0400; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL reset pre-abort rd_en: got %b want 1", rd_en); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({fm_addr, wt_addr, rd_en, mac_clr, mac_en, mac_last, busy, result_valid} !== '0 ||
        {l3_rd_en, l3_mac_en, l3_busy, l3_fm_addr} !== '0) begin
      n_fail++; $display("FAIL abort outputs: got fm %h wt %h rd %b busy %b l3en %b want all 0",
                         fm_addr, wt_addr, rd_en, busy, l3_mac_en);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin n_fail++; $display("FAIL abort idle: got busy %b rv %b want 0 0", busy, result_valid); end
  endtask

  task automatic test_sweep();
    for (int k = 0; k < 27; k++) scores[k] = 21'(k);
    run_scores(9'h010, 13'h0100, 1'b0, 5'd26, "sweep");
  endtask

  task automatic test_argmax();
    for (int k = 0; k < 27; k++) scores[k] = 21'(k * 10);
    scores[13] = 21'sh07FFF0;
    run_scores(9'h1F0, 13'h1FFF, 1'b0, 5'd13, "argmax");
  endtask

  task automatic test_neg_ties();
    for (int k = 0; k < 27; k++) scores[k] = -21'sd5;
    scores[4] = -21'sd1;
    scores[9] = -21'sd1;
    run_scores(9'h000, 13'h0000, 1'b0, 5'd4, "ties");
  endtask

  task automatic test_handshake();
    for (int k = 0; k < 27; k++) scores[k] = -21'sd100 + 21'(k);
    scores[20] = 21'sd7;
    run_scores(9'h055, 13'h0AAA, 1'b1, 5'd20, "handshake");
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_argmax();
    test_neg_ties();
    test_handshake();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
